// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared MLP constants and argmax sequencer state type
package mlp_pkg;
    localparam int IN_DIM  = 64;
    localparam int H_DIM   = 8;
    localparam int OUT_DIM = 10;
    localparam int ACCW    = 32;
    localparam int CLS_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;
endpackage

// File: rtl/mlp_argmax_seq_if.sv
// rtl/mlp_argmax_seq_if.sv - logit input and classification result handshake bundle
interface mlp_argmax_seq_if #(
    parameter int OUT_DIM = mlp_pkg::OUT_DIM,
    parameter int ACCW    = mlp_pkg::ACCW,
    parameter int CLS_W   = mlp_pkg::CLS_W
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic [OUT_DIM*ACCW-1:0]  logits_flat;
    logic                     out_valid;
    logic                     out_ready;
    logic [CLS_W-1:0]         class_idx;
    logic [ACCW-1:0]          top1_logit;
    logic [ACCW-1:0]          margin;

    // Producer/consumer side (testbench or surrounding datapath)
    modport master (
        output in_valid, logits_flat, out_ready,
        input  in_ready, out_valid, class_idx, top1_logit, margin
    );

    // Argmax sequencer side
    modport slave (
        input  in_valid, logits_flat, out_ready,
        output in_ready, out_valid, class_idx, top1_logit, margin
    );
endinterface

// File: rtl/mlp_top2_update.sv
// rtl/mlp_top2_update.sv - one-logit step of the top1/top2 tracker
module mlp_top2_update #(
    parameter int ACCW  = mlp_pkg::ACCW,
    parameter int CLS_W = mlp_pkg::CLS_W
) (
    input  logic signed [ACCW-1:0] i_v,
    input  logic [CLS_W-1:0]       i_idx,
    input  logic signed [ACCW-1:0] i_top1,
    input  logic signed [ACCW-1:0] i_top2,
    input  logic [CLS_W-1:0]       i_top1_idx,
    input  logic                   i_top2_loaded,
    output logic signed [ACCW-1:0] o_top1,
    output logic signed [ACCW-1:0] o_top2,
    output logic [CLS_W-1:0]       o_top1_idx,
    output logic                   o_top2_loaded
);
    // Index 0 always seeds top1; strict compares keep ties on the lowest index
    always_comb begin
        o_top1        = i_top1;
        o_top2        = i_top2;
        o_top1_idx    = i_top1_idx;
        o_top2_loaded = i_top2_loaded;
        if (i_idx == '0) begin
            o_top1     = i_v;
            o_top1_idx = i_idx;
        end else if (i_v > i_top1) begin
            o_top2        = i_top1;
            o_top2_loaded = 1'b1;
            o_top1        = i_v;
            o_top1_idx    = i_idx;
        end else if (!i_top2_loaded || (i_v > i_top2)) begin
            o_top2        = i_v;
            o_top2_loaded = 1'b1;
        end
    end
endmodule

// File: rtl/mlp_argmax_seq.sv
// rtl/mlp_argmax_seq.sv - sequential argmax with confidence margin over the MLP logits
module mlp_argmax_seq #(
    parameter int OUT_DIM = mlp_pkg::OUT_DIM,
    parameter int ACCW    = mlp_pkg::ACCW,
    parameter int CLS_W   = mlp_pkg::CLS_W
) (
    input  logic            clk,
    input  logic            rst,
    mlp_argmax_seq_if.slave bus
);
    import mlp_pkg::*;

    localparam logic [CLS_W-1:0] LAST_IDX   = CLS_W'(OUT_DIM - 1);
    localparam logic [ACCW-1:0]  MARGIN_MAX = {1'b0, {(ACCW-1){1'b1}}};

    state_t                  r_state;
    logic [OUT_DIM*ACCW-1:0] r_logits;
    logic [CLS_W-1:0]        r_idx;
    logic signed [ACCW-1:0]  r_top1;
    logic signed [ACCW-1:0]  r_top2;
    logic [CLS_W-1:0]        r_top1_idx;
    logic                    r_top2_loaded;
    logic                    r_out_valid;
    logic [CLS_W-1:0]        r_class_idx;
    logic [ACCW-1:0]         r_top1_logit;
    logic [ACCW-1:0]         r_margin;

    logic signed [ACCW-1:0]  w_v;
    logic signed [ACCW-1:0]  w_top1;
    logic signed [ACCW-1:0]  w_top2;
    logic [CLS_W-1:0]        w_top1_idx;
    logic                    w_top2_loaded;
    logic [ACCW:0]           w_diff;
    logic [ACCW-1:0]         w_margin;

    assign w_v = r_logits[int'(r_idx)*ACCW +: ACCW];

    mlp_top2_update #(
        .ACCW  (ACCW),
        .CLS_W (CLS_W)
    ) u_update (
        .i_v           (w_v),
        .i_idx         (r_idx),
        .i_top1        (r_top1),
        .i_top2        (r_top2),
        .i_top1_idx    (r_top1_idx),
        .i_top2_loaded (r_top2_loaded),
        .o_top1        (w_top1),
        .o_top2        (w_top2),
        .o_top1_idx    (w_top1_idx),
        .o_top2_loaded (w_top2_loaded)
    );

    // Sign-extended difference cannot overflow; top1 >= top2 so the MSB stays clear
    assign w_diff   = {w_top1[ACCW-1], w_top1} - {w_top2[ACCW-1], w_top2};
    assign w_margin = (!w_top2_loaded || w_diff[ACCW] || w_diff[ACCW-1]) ? MARGIN_MAX
                                                                         : w_diff[ACCW-1:0];

    assign bus.in_ready   = (r_state == IDLE) && !rst;
    assign bus.out_valid  = r_out_valid;
    assign bus.class_idx  = r_class_idx;
    assign bus.top1_logit = r_top1_logit;
    assign bus.margin     = r_margin;

    // Capture -> scan one logit per cycle -> hold result until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_logits      <= '0;
            r_idx         <= '0;
            r_top1        <= '0;
            r_top2        <= '0;
            r_top1_idx    <= '0;
            r_top2_loaded <= 1'b0;
            r_out_valid   <= 1'b0;
            r_class_idx   <= '0;
            r_top1_logit  <= '0;
            r_margin      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_logits      <= bus.logits_flat;
                        r_idx         <= '0;
                        r_top1        <= '0;
                        r_top2        <= '0;
                        r_top1_idx    <= '0;
                        r_top2_loaded <= 1'b0;
                        r_state       <= SCAN;
                    end
                end
                SCAN: begin
                    r_top1        <= w_top1;
                    r_top2        <= w_top2;
                    r_top1_idx    <= w_top1_idx;
                    r_top2_loaded <= w_top2_loaded;
                    if (r_idx == LAST_IDX) begin
                        r_state      <= DONE;
                        r_out_valid  <= 1'b1;
                        r_class_idx  <= w_top1_idx;
                        r_top1_logit <= w_top1;
                        r_margin     <= w_margin;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mlp_argmax_seq.md
Name: mlp_argmax_seq

Overview:
- Downstream stage of the combinational 64->8->10 MLP forward pass.
- Captures the flattened int32 logit vector under a valid/ready handshake and scans one logit per clock.
- Tracks the largest and second-largest logits; reports the winning class index, its logit, and the top1-top2 confidence margin under a second valid/ready handshake.
- Results feed the classification result register and the testbench scoreboard.

Parameters:
- OUT_DIM, 10, number of logits (classes).
- ACCW, 32, signed logit width (int32).
- CLS_W, 4, class index width; must be at least $clog2(OUT_DIM).

Ports:
- clk  input  1  Single clock; all state changes on its rising edge.
- rst  input  1  Synchronous, active-high reset.
- in_valid  input  1  logits_flat holds a valid vector.
- in_ready  output  1  Block can accept a vector.
- logits_flat  input  OUT_DIM*ACCW  Signed logits; logit k in bits [k*ACCW +: ACCW].
- out_valid  output  1  Result outputs valid.
- out_ready  input  1  Consumer accepts the result.
- class_idx  output  CLS_W  Index of the maximum logit.
- top1_logit  output  ACCW  Signed maximum logit value.
- margin  output  ACCW  Unsigned top1 minus top2, saturated.

Behaviour:
- Reset is synchronous and active-high on clk. It applies in any state, including mid-SCAN or DONE; an in-flight vector is discarded with no output.
- Reset values:
  - state=IDLE.
  - out_valid=0, class_idx=0, top1_logit=0, margin=0.
  - scan index=0, captured vector cleared.
  - in_ready=0 while rst=1.
- States:
  - IDLE: in_ready=1 (when rst=0).
  - SCAN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE -> SCAN on in_valid & in_ready. The full vector is registered internally, idx=0, top1/top2 trackers are initialised from nothing (first logit always loads top1).
- SCAN: each cycle processes logit[idx], then idx increments.
  - If v > top1 (signed compare): top2 <- top1; top1 <- v; top1_idx <- idx.
  - Else if v > top2 (or top2 not yet loaded): top2 <- v.
  - Ties go to the lowest index: an equal value never replaces top1, but may update top2.
  - After processing idx=OUT_DIM-1, go to DONE.
- SCAN -> DONE transition:
  - Register class_idx=top1_idx and top1_logit=top1.
  - margin = top1 - top2, computed in ACCW+1 bits. Result is always >= 0; saturate to 2^(ACCW-1)-1 if it exceeds that value.
- Latency: out_valid rises OUT_DIM clock edges after the capture edge (10 for defaults).
- DONE: all outputs held stable until out_ready=1. On out_valid & out_ready -> IDLE, out_valid=0 next cycle.
- No same-cycle accept in DONE; throughput is one vector per OUT_DIM+2 cycles minimum.
- in_valid while not in IDLE is ignored; the upstream source must hold its data until in_ready.
- logits_flat is sampled only on the capture edge; later changes do not affect the scan.
- out_ready while out_valid=0 has no effect.
- OUT_DIM=1: top2 is never loaded; margin = saturated max value, class_idx=0.

Decomposition:
- Package mlp_pkg:
  - Constants IN_DIM=64, H_DIM=8, OUT_DIM=10, ACCW=32, CLS_W=4.
  - State enum {IDLE, SCAN, DONE}.
  - Shared with the forward-pass block.
- Sub-module mlp_top2_update (combinational):
  - Inputs: v, idx, top1, top2, top1_idx, top2_loaded.
  - Outputs: next top1, top2, top1_idx, top2_loaded.
  - Unit-testable in isolation.
- The FSM, capture register, index counter and margin saturation stay in mlp_argmax_seq.

Test Plan:
- Basic argmax: logits {5,-3,100,7,0,1,2,3,4,99} -> class_idx=2, top1_logit=100, margin=1, out_valid exactly 10 cycles after capture.
- All negative: {-50,-2,-9,-2,-100,-7,-8,-30,-4,-3} -> class_idx=1 (tie with idx 3, lowest wins), top1_logit=-2, margin=0.
- Margin saturation: logit0=2147483647, all others -2147483648 -> class_idx=0, margin=2147483647.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> outputs stable and in_ready=0 throughout. A new in_valid pulse is ignored. Raising out_ready returns to IDLE with in_ready=1 the next cycle.
- Reset mid-scan: assert rst 4 cycles after capture -> out_valid never asserts, outputs 0. A subsequent vector {0,0,0,0,0,0,0,0,0,9} yields class_idx=9, margin=9.
- Back-to-back: in_valid held high with two different vectors and out_ready=1 -> two results in order, second capture occurs the cycle after the first handshake.
